// File: rtl/tetris_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module   : tetris_cmd_queue
// Brief    : Validates framed MCU command bytes, buffers them in a small
//            first-word-fall-through FIFO and hands them to the game-state
//            FSM over valid/ready. Keeps saturating bad/overflow counters.
// Revision : 1.0 - initial release
// ============================================================================

package tetris_pkg;
    typedef enum logic [2:0] {
        CMD_NONE      = 3'd0,
        CMD_LEFT      = 3'd1,
        CMD_RIGHT     = 3'd2,
        CMD_ROTATE    = 3'd3,
        CMD_SOFT_DROP = 3'd4
    } command_t;
endpackage

module tetris_cmd_queue #(
    parameter int         DEPTH  = 4,
    parameter logic [3:0] HEADER = 4'hA,
    parameter int         CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [7:0]               rx_byte,
    input  logic                     rx_valid,
    input  logic                     flush,
    output logic [2:0]               cmd,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         bad_cnt,
    output logic [CNT_W-1:0]         ovf_cnt
);

    localparam int                   c_IDX_W   = $clog2(DEPTH);
    localparam int                   c_PTR_W   = c_IDX_W + 1;
    localparam logic [c_PTR_W-1:0]   c_PTR_ONE = 1;
    localparam logic [CNT_W-1:0]     c_CNT_ONE = 1;
    localparam logic [CNT_W-1:0]     c_CNT_MAX = '1;

    tetris_pkg::command_t r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]     r_bad_cnt;
    logic [CNT_W-1:0]     r_ovf_cnt;

    logic w_byte_ok;
    logic w_bad;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_byte_ok = (rx_byte[7:4] == HEADER) && !rx_byte[3] &&
                       (rx_byte[2:0] != 3'd0) && (rx_byte[2:0] <= 3'd4);
    assign w_bad     = rx_valid && !w_byte_ok;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_IDX_W] != r_rd_ptr[c_IDX_W]) &&
                     (r_wr_ptr[c_IDX_W-1:0] == r_rd_ptr[c_IDX_W-1:0]);

    // A pop frees the slot the same-cycle push needs, so full+pop still accepts.
    assign w_pop  = !flush && !w_empty && cmd_ready;
    assign w_push = !flush && rx_valid && w_byte_ok && (!w_full || w_pop);
    assign w_drop = !flush && rx_valid && w_byte_ok && w_full && !w_pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[c_IDX_W-1:0]] <= tetris_pkg::command_t'(rx_byte[2:0]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bad_cnt <= '0;
            r_ovf_cnt <= '0;
        end else begin
            if (w_bad && (r_bad_cnt != c_CNT_MAX))  r_bad_cnt <= r_bad_cnt + c_CNT_ONE;
            if (w_drop && (r_ovf_cnt != c_CNT_MAX)) r_ovf_cnt <= r_ovf_cnt + c_CNT_ONE;
        end
    end

    assign cmd_valid  = !w_empty;
    assign cmd        = w_empty ? tetris_pkg::CMD_NONE : r_mem[r_rd_ptr[c_IDX_W-1:0]];
    assign fifo_count = r_wr_ptr - r_rd_ptr;
    assign bad_cnt    = r_bad_cnt;
    assign ovf_cnt    = r_ovf_cnt;

endmodule

`default_nettype wire

// File: tb/tb_tetris_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_tetris_cmd_queue
// Brief    : Directed and random checks of tetris_cmd_queue against a
//            queue-based reference model (default width and CNT_W=2 copies).
// Revision : 1.0 - initial release
// ============================================================================

module tb_tetris_cmd_queue;

    localparam int DEPTH = 4;

    logic       clk;
    logic       reset_n;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       flush;
    logic       cmd_ready;

    logic [2:0] cmd,        cmd_s;
    logic       cmd_valid,  cmd_valid_s;
    logic [2:0] fifo_count, fifo_count_s;
    logic [7:0] bad_cnt,    ovf_cnt;
    logic [1:0] bad_cnt_s,  ovf_cnt_s;

    int tests  = 0;
    int failed = 0;

    int q[$];
    int m_bad = 0;
    int m_ovf = 0;

    tetris_cmd_queue #(.DEPTH(DEPTH), .HEADER(4'hA), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .flush(flush), .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .fifo_count(fifo_count), .bad_cnt(bad_cnt), .ovf_cnt(ovf_cnt)
    );

    tetris_cmd_queue #(.DEPTH(DEPTH), .HEADER(4'hA), .CNT_W(2)) dut_s (
        .clk(clk), .reset_n(reset_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .flush(flush), .cmd(cmd_s), .cmd_valid(cmd_valid_s), .cmd_ready(cmd_ready),
        .fifo_count(fifo_count_s), .bad_cnt(bad_cnt_s), .ovf_cnt(ovf_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic check_all(input string ph);
        int head;
        head = (q.size() != 0) ? q[0] : 0;
        chk({ph, ":cmd_valid"},    {31'd0, cmd_valid},     (q.size() != 0) ? 1 : 0);
        chk({ph, ":cmd"},          {29'd0, cmd},           head);
        chk({ph, ":fifo_count"},   {29'd0, fifo_count},    q.size());
        chk({ph, ":bad_cnt"},      {24'd0, bad_cnt},       sat(m_bad, 255));
        chk({ph, ":ovf_cnt"},      {24'd0, ovf_cnt},       sat(m_ovf, 255));
        chk({ph, ":s_cmd"},        {29'd0, cmd_s},         head);
        chk({ph, ":s_fifo_count"}, {29'd0, fifo_count_s},  q.size());
        chk({ph, ":s_bad_cnt"},    {30'd0, bad_cnt_s},     sat(m_bad, 3));
        chk({ph, ":s_ovf_cnt"},    {30'd0, ovf_cnt_s},     sat(m_ovf, 3));
    endtask

    // Reference: legal frame = header A, bit3 clear, code 1..4.
    task automatic model_edge(input logic [7:0] b, input logic v, input logic r, input logic f);
        bit ok;
        bit pop;
        ok = v && (b[7:4] == 4'hA) && !b[3] && (b[2:0] >= 3'd1) && (b[2:0] <= 3'd4);
        if (v && !ok) m_bad++;
        if (f) begin
            q.delete();
        end else begin
            pop = (q.size() != 0) && r;
            if (ok && (q.size() == DEPTH) && !pop) m_ovf++;
            if (pop) void'(q.pop_front());
            if (ok && (q.size() < DEPTH)) q.push_back(int'(b[2:0]));
        end
    endtask

    // Called at a falling edge: drive, clock, update model, check at next falling edge.
    task automatic cycle(input string ph, input logic [7:0] b, input logic v, input logic r, input logic f);
        rx_byte = b; rx_valid = v; cmd_ready = r; flush = f;
        @(posedge clk);
        model_edge(b, v, r, f);
        @(negedge clk);
        check_all(ph);
    endtask

    task automatic async_reset(input string ph);
        #2;
        reset_n = 1'b0;
        q.delete(); m_bad = 0; m_ovf = 0;
        #1;
        check_all({ph, ":async"});
        rx_valid = 1'b0; flush = 1'b0; cmd_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check_all({ph, ":released"});
    endtask

    initial begin
        logic [7:0] seq [4];
        logic [7:0] b;
        reset_n = 1'b0; rx_byte = 8'h00; rx_valid = 1'b0; flush = 1'b0; cmd_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_all("reset");
        reset_n = 1'b1;

        // 1: single command latency and pop
        cycle("t1_push", 8'hA1, 1'b1, 1'b0, 1'b0);
        cycle("t1_hold", 8'h00, 1'b0, 1'b0, 1'b0);
        cycle("t1_hold2", 8'h00, 1'b0, 1'b0, 1'b0);
        cycle("t1_pop", 8'h00, 1'b0, 1'b1, 1'b0);

        // 2: back-to-back with consumer always ready
        seq[0] = 8'hA3; seq[1] = 8'hA2; seq[2] = 8'hA4; seq[3] = 8'hA1;
        for (int i = 0; i < 4; i++) cycle("t2_stream", seq[i], 1'b1, 1'b1, 1'b0);
        cycle("t2_drain", 8'h00, 1'b0, 1'b1, 1'b0);

        // 3: malformed bytes
        seq[0] = 8'hB1; seq[1] = 8'hA0; seq[2] = 8'hA7; seq[3] = 8'hA9;
        for (int i = 0; i < 4; i++) cycle("t3_bad", seq[i], 1'b1, 1'b0, 1'b0);

        // 4: overflow drop, then full push+pop
        seq[0] = 8'hA1; seq[1] = 8'hA2; seq[2] = 8'hA3; seq[3] = 8'hA4;
        for (int i = 0; i < 4; i++) cycle("t4_fill", seq[i], 1'b1, 1'b0, 1'b0);
        cycle("t4_drop", 8'hA2, 1'b1, 1'b0, 1'b0);
        cycle("t4_pushpop", 8'hA3, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle("t4_drain", 8'h00, 1'b0, 1'b1, 1'b0);

        // 5: flush beats same-cycle push
        for (int i = 0; i < 3; i++) cycle("t5_fill", seq[i], 1'b1, 1'b0, 1'b0);
        cycle("t5_flush", 8'hA1, 1'b1, 1'b0, 1'b1);
        cycle("t5_after", 8'h00, 1'b0, 1'b0, 1'b0);

        // 6: CNT_W=2 saturation, then async reset mid-stream
        for (int i = 0; i < 5; i++) cycle("t6_sat", 8'hA5, 1'b1, 1'b0, 1'b0);
        cycle("t6_q1", 8'hA2, 1'b1, 1'b0, 1'b0);
        cycle("t6_q2", 8'hA4, 1'b1, 1'b0, 1'b0);
        async_reset("t6");

        // Random traffic, mostly well-framed
        for (int n = 0; n < 400; n++) begin
            b[7:4] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hA;
            b[3:0] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(1, 4));
            cycle("rand", b, ($urandom_range(0, 9) < 7), ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 39) == 0));
            if (n == 200) async_reset("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
